// File: rtl/font_rom_arbiter_if.sv
// Requester/ROM-side bundle for font_rom_arbiter.
// master: text layers plus ROM model; slave: the arbiter.
interface font_rom_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        gnt;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      rom_data;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   busy;

    modport master (
        output req, req_lock, req_addr, rom_data,
        input  gnt, rom_addr, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req, req_lock, req_addr, rom_data,
        output gnt, rom_addr, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// Shares one glyph ROM between text layers: round-robin grant, optional lock.
// Define FONT_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module font_rom_arbiter #(
    parameter int NREQ     = 4,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 16
) (
    input logic               clk,
    input logic               rst_n,
    font_rom_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {UNLOCKED, LOCKED} state_e;

    state_e            st_q, st_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  lcnt_q, lcnt_d;

    logic [NREQ-1:0]   s1_tag_q, s2_tag_q, rsp_valid_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              busy_q;

    logic              hold, forced, found;
    logic [NREQ-1:0]   cand, gnt;
    logic [IDX_W-1:0]  win;
    logic [ADDR_W-1:0] sel_addr;

    always_comb begin
        hold   = (st_q == LOCKED) && bus.req[owner_q]
                 && (int'(lcnt_q) < MAX_LOCK);
        forced = (st_q == LOCKED) && bus.req[owner_q] && !hold;

        // A capped owner yields to anyone else pending, else keeps going.
        cand = bus.req;
        if (forced) cand[owner_q] = 1'b0;
        if (cand == '0) cand = bus.req;

        found = 1'b0;
        win   = '0;
`ifdef FONT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!found && cand[i]) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && cand[(int'(last_q) + k) % NREQ]) begin
                found = 1'b1;
                win   = IDX_W'((int'(last_q) + k) % NREQ);
            end
        end
`endif
        if (hold) begin
            found = 1'b1;
            win   = owner_q;
        end

        gnt = '0;
        if (rst_n && found) gnt[win] = 1'b1;

        sel_addr = rom_addr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        end

        st_d    = st_q;
        owner_d = owner_q;
        lcnt_d  = lcnt_q;
        last_d  = last_q;
        if (found) last_d = win;
        if (hold) begin
            if (bus.req_lock[owner_q]) begin
                lcnt_d = lcnt_q + CNT_W'(1);
            end else begin
                st_d   = UNLOCKED;
                lcnt_d = '0;
            end
        end else if (found && bus.req_lock[win]) begin
            st_d    = LOCKED;
            owner_d = win;
            lcnt_d  = CNT_W'(1);
        end else begin
            st_d   = UNLOCKED;
            lcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= UNLOCKED;
            owner_q     <= '0;
            lcnt_q      <= '0;
            last_q      <= IDX_W'(NREQ - 1);
            s1_tag_q    <= '0;
            s2_tag_q    <= '0;
            rsp_valid_q <= '0;
            rom_addr_q  <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            owner_q     <= owner_d;
            lcnt_q      <= lcnt_d;
            last_q      <= last_d;
            s1_tag_q    <= gnt;
            rom_addr_q  <= sel_addr;
            s2_tag_q    <= s1_tag_q;
            rsp_valid_q <= s2_tag_q;
            if (|s2_tag_q) rsp_data_q <= bus.rom_data;
            busy_q      <= (|gnt) | (|s1_tag_q);
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: scoreboarded responses, per-scenario tasks.
// Build with FONT_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_font_rom_arbiter;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;

    typedef struct {
        int         due;
        logic [3:0] tag;
        logic [7:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [10:0] addr[4];

    font_rom_arbiter_if #(.NREQ(4), .ADDR_W(11), .DATA_W(8)) bus ();

    font_rom_arbiter #(
        .NREQ(4), .ADDR_W(11), .DATA_W(8), .MAX_LOCK(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], 5'b10110};
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    function automatic logic [3:0] oh(input int idx);
        return (idx < 0) ? 4'b0000 : 4'(1 << idx);
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] l);
        bus.req      = r;
        bus.req_lock = l;
    endtask

    task automatic set_addr(input logic [10:0] a0, a1, a2, a3);
        addr[0] = a0;
        addr[1] = a1;
        addr[2] = a2;
        addr[3] = a3;
        for (int i = 0; i < 4; i++) bus.req_addr[i*11 +: 11] = addr[i];
    endtask

    task automatic expect_rsp(input int idx);
        if (idx >= 0) sb.push_back('{cyc + 3, oh(idx), rom_fn(addr[idx])});
    endtask

    task automatic idle(input int n);
        drive(4'b0000, 4'b0000);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0000) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected: got valid=%b data=%h, required none",
                             bus.rsp_valid, bus.rsp_data);
                end else begin
                    e = sb.pop_front();
                    if (e.due !== cyc || bus.rsp_valid !== e.tag
                        || bus.rsp_data !== e.data)
                        $display("FAIL rsp: got cyc=%0d valid=%b data=%h, required cyc=%0d valid=%b data=%h",
                                 cyc, bus.rsp_valid, bus.rsp_data,
                                 e.due, e.tag, e.data);
                    else
                        n_pass++;
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                n_chk++;
                e = sb.pop_front();
                $display("FAIL rsp_missing: got valid=0 at cyc=%0d, required valid=%b data=%h",
                         cyc, e.tag, e.data);
            end
        end
    endtask

    task automatic test_reset();
        drive(4'b1111, 4'b1111);
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 4'b0000)
            $display("FAIL reset gnt: got %b, required 0000", bus.gnt);
        else n_pass++;
        n_chk++;
        if (bus.rom_addr !== 11'h000)
            $display("FAIL reset rom_addr: got %h, required 000", bus.rom_addr);
        else n_pass++;
        n_chk++;
        if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 8'h00)
            $display("FAIL reset rsp: got %b/%h, required 0000/00",
                     bus.rsp_valid, bus.rsp_data);
        else n_pass++;
        n_chk++;
        if (bus.busy !== 1'b0)
            $display("FAIL reset busy: got %b, required 0", bus.busy);
        else n_pass++;
        @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000);
    endtask

    task automatic test_single_read();
        logic [3:0] eg[4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic       eb[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        set_addr(11'h208, 11'h111, 11'h222, 11'h333);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive((k == 0) ? 4'b0001 : 4'b0000, 4'b0000);
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== eg[k])
                $display("FAIL single gnt[%0d]: got %b, required %b",
                         k, bus.gnt, eg[k]);
            else n_pass++;
            n_chk++;
            if (bus.busy !== eb[k])
                $display("FAIL single busy[%0d]: got %b, required %b",
                         k, bus.busy, eb[k]);
            else n_pass++;
            if (k > 0) begin
                n_chk++;
                if (bus.rom_addr !== 11'h208)
                    $display("FAIL single rom_addr[%0d]: got %h, required 208",
                             k, bus.rom_addr);
                else n_pass++;
            end
            if (k == 0) expect_rsp(0);
            @(posedge clk);
            #1;
        end
        idle(3);
    endtask

    task automatic test_round_robin();
`ifdef FONT_ARB_FIXED_PRIO_EN
        int e[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        int e[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
        set_addr(11'h041, 11'h0A2, 11'h3F3, 11'h7FF);
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 4'b0000);
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== oh(e[k]))
                $display("FAIL rr gnt[%0d]: got %b, required %b",
                         k, bus.gnt, oh(e[k]));
            else n_pass++;
            expect_rsp(e[k]);
            @(posedge clk);
            #1;
        end
        idle(4);
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0)
            $display("FAIL rr busy_after: got %b, required 0", bus.busy);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock_cap();
        logic [3:0] r[9] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                             4'b0101, 4'b1101, 4'b1101, 4'b1101};
        logic [3:0] l[9] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                             4'b0100, 4'b0100, 4'b0000, 4'b0000};
`ifdef FONT_ARB_FIXED_PRIO_EN
        int e[9] = '{2, 2, 2, 2, 0, 0, 0, 0, 0};
`else
        int e[9] = '{2, 2, 2, 2, 0, 2, 2, 2, 3};
`endif
        set_addr(11'h100, 11'h201, 11'h402, 11'h603);
        for (int k = 0; k < 9; k++) begin
            drive(r[k], l[k]);
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== oh(e[k]))
                $display("FAIL lock_cap gnt[%0d]: got %b, required %b",
                         k, bus.gnt, oh(e[k]));
            else n_pass++;
            expect_rsp(e[k]);
            @(posedge clk);
            #1;
        end
        idle(4);
    endtask

    task automatic test_lock_drop_req();
        logic [3:0] r[4] = '{4'b1000, 4'b1010, 4'b0010, 4'b0000};
        logic [3:0] l[4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000};
        int         e[4] = '{3, 3, 1, -1};
        set_addr(11'h055, 11'h1AA, 11'h2CC, 11'h533);
        for (int k = 0; k < 4; k++) begin
            drive(r[k], l[k]);
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== oh(e[k]))
                $display("FAIL lock_drop gnt[%0d]: got %b, required %b",
                         k, bus.gnt, oh(e[k]));
            else n_pass++;
            expect_rsp(e[k]);
            @(posedge clk);
            #1;
        end
        idle(4);
    endtask

    task automatic test_reset_midflight();
`ifdef FONT_ARB_FIXED_PRIO_EN
        int e[3] = '{0, 0, 0};
`else
        int e[3] = '{2, 0, 1};
`endif
        set_addr(11'h010, 11'h020, 11'h030, 11'h040);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0111, 4'b0000);
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== oh(e[k]))
                $display("FAIL midrst gnt[%0d]: got %b, required %b",
                         k, bus.gnt, oh(e[k]));
            else n_pass++;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)
            $display("FAIL midrst in_reset: got gnt=%b busy=%b, required 0000/0",
                     bus.gnt, bus.busy);
        else n_pass++;
        @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0)
                $display("FAIL midrst after[%0d]: got valid=%b busy=%b, required 0000/0",
                         k, bus.rsp_valid, bus.busy);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_prio_1110();
`ifdef FONT_ARB_FIXED_PRIO_EN
        int e[6] = '{1, 1, 1, 1, 1, 1};
`else
        int e[6] = '{1, 2, 3, 1, 2, 3};
`endif
        set_addr(11'h7F0, 11'h3C1, 11'h4D2, 11'h0E3);
        for (int k = 0; k < 6; k++) begin
            drive(4'b1110, 4'b0000);
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== oh(e[k]))
                $display("FAIL prio1110 gnt[%0d]: got %b, required %b",
                         k, bus.gnt, oh(e[k]));
            else n_pass++;
            expect_rsp(e[k]);
            @(posedge clk);
            #1;
        end
        idle(5);
    endtask

    initial begin
        cyc          = 0;
        n_chk        = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_lock = '0;
        bus.req_addr = '0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_cap();
        test_lock_drop_req();
        test_reset_midflight();
        test_prio_1110();
        n_chk++;
        if (sb.size() != 0)
            $display("FAIL drain: got %0d pending responses, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
